add_mop_seq: RTL and testbench



---
 rtl/add_mop_seq_if.sv | 23 ++
 rtl/add_mop_seq.sv | 161 ++++++++++++++++
 tb/tb_add_mop_seq.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_mop_seq_if.sv
// Operand/sum valid-ready stream bundle for the sequential multi-operand adder.
// The slave side is the adder; the master side is whoever feeds operands and takes sums.
interface add_mop_seq_if #(
   parameter int width = 8
);
   logic             AValid;
   logic             AReady;
   logic [width-1:0] A;
   logic             ASub;
   logic             SValid;
   logic             SReady;
   logic [width-1:0] S;

   modport slave (
      input  AValid, A, ASub, SReady,
      output AReady, SValid, S
   );

   modport master (
      output AValid, A, ASub, SReady,
      input  AReady, SValid, S
   );
endinterface

// File: rtl/add_mop_seq.sv
// Sequential multi-operand adder: carry-save accumulation of one operand per cycle,
// followed by a single carry-propagate resolve and a held valid/ready result.

// Carry-propagate adder, sum modulo 2^width. speed: 0 ripple, 1 Brent-Kung, 2 Sklansky.
module add_mop_seq_cpa #(
   parameter int width = 8,
   parameter int speed = 1
) (
   input  logic [width-1:0] a_i,
   input  logic [width-1:0] b_i,
   output logic [width-1:0] s_o
);
   // Only carries out of the low width-1 bits reach the sum; the final carry is dropped.
   localparam int N  = width - 1;
   localparam int LV = (N > 1) ? $clog2(N) : 0;

   always_comb begin
      logic [N-1:0] gv;
      logic [N-1:0] pv;
      logic [N-1:0] gn;
      logic [N-1:0] pn;
      int           j;
      gv = a_i[N-1:0] & b_i[N-1:0];
      pv = a_i[N-1:0] ^ b_i[N-1:0];
      gn = gv;
      pn = pv;
      j  = 0;
      if (speed == 0) begin
         for (int i = 1; i < N; i++)
            gv[i] = gv[i] | (pv[i] & gv[i-1]);
      end else if (speed == 2) begin
         for (int l = 0; l < LV; l++) begin
            gn = gv;
            pn = pv;
            for (int i = 0; i < N; i++) begin
               if (((i >> l) & 1) == 1) begin
                  j     = ((i >> l) << l) - 1;
                  gn[i] = gv[i] | (pv[i] & gv[j]);
                  pn[i] = pv[i] & pv[j];
               end
            end
            gv = gn;
            pv = pn;
         end
      end else begin
         // Up-sweep builds power-of-two spans; down-sweep fills the gaps in place.
         for (int l = 0; l < LV; l++) begin
            for (int i = 0; i < N; i++) begin
               if (((i + 1) % (2 ** (l + 1))) == 0) begin
                  j     = i - (2 ** l);
                  gv[i] = gv[i] | (pv[i] & gv[j]);
                  pv[i] = pv[i] & pv[j];
               end
            end
         end
         for (int l = LV - 2; l >= 0; l--) begin
            for (int i = 2 ** (l + 1); i < N; i++) begin
               if (((i + 1) % (2 ** (l + 1))) == (2 ** l)) begin
                  j     = i - (2 ** l);
                  gv[i] = gv[i] | (pv[i] & gv[j]);
                  pv[i] = pv[i] & pv[j];
               end
            end
         end
      end
      s_o = (a_i ^ b_i) ^ {gv, 1'b0};
   end
endmodule

// state   | meaning
// ACCUM   | accepting operands into the carry-save pair
// RESOLVE | one cycle: carry-propagate add of ST and CT into S
// DONE    | S presented with SValid until SReady
module add_mop_seq #(
   parameter int width = 8,
   parameter int depth = 4,
   parameter int speed = 1
) (
   input  logic         CLK,
   input  logic         RST,
   add_mop_seq_if.slave bus
);
   localparam int CW = $clog2(depth + 1);

   typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [width-1:0] st_q, st_d;
   logic [width-1:0] ct_q, ct_d;
   logic [width-1:0] s_q, s_d;
   logic [width-1:0] a_eff;
   logic [width-1:0] maj;
   logic [width-1:0] sum;
   logic             accept;

   add_mop_seq_cpa #(.width(width), .speed(speed)) u_cpa (
      .a_i (st_q),
      .b_i (ct_q),
      .s_o (sum)
   );

   // Ready is gated by RST so it stays low for the whole reset window.
   assign bus.AReady = (state_q == ACCUM) & ~RST;
   assign bus.SValid = (state_q == DONE);
   assign bus.S      = s_q;
   assign accept     = bus.AValid & bus.AReady;
   assign a_eff      = bus.ASub ? ~bus.A : bus.A;
   assign maj        = (st_q & ct_q) | (st_q & a_eff) | (ct_q & a_eff);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      st_d    = st_q;
      ct_d    = ct_q;
      s_d     = s_q;
      unique case (state_q)
         ACCUM: begin
            if (accept) begin
               st_d = st_q ^ ct_q ^ a_eff;
               // Carry shifts left, so bit 0 is free for the two's-complement +1.
               ct_d = {maj[width-2:0], bus.ASub};
               if (cnt_q == CW'(depth - 1)) begin
                  cnt_d   = '0;
                  state_d = RESOLVE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         RESOLVE: begin
            s_d     = sum;
            state_d = DONE;
         end
         DONE: begin
            if (bus.SReady) begin
               st_d    = '0;
               ct_d    = '0;
               state_d = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ACCUM;
         cnt_q   <= '0;
         st_q    <= '0;
         ct_q    <= '0;
         s_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         st_q    <= st_d;
         ct_q    <= ct_d;
         s_q     <= s_d;
      end
   end
endmodule

// File: tb/tb_add_mop_seq.sv
// Scoreboard bench: directed sets on an 8-bit/depth-4 instance, then random
// sets shared by three 16-bit/depth-5 instances (ripple, Brent-Kung, Sklansky).
module tb_add_mop_seq;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   add_mop_seq_if #(.width(8))  ifa ();
   add_mop_seq_if #(.width(16)) ifb0 ();
   add_mop_seq_if #(.width(16)) ifb1 ();
   add_mop_seq_if #(.width(16)) ifb2 ();

   add_mop_seq #(.width(8),  .depth(4), .speed(1)) dut_a  (.CLK(clk), .RST(rst), .bus(ifa.slave));
   add_mop_seq #(.width(16), .depth(5), .speed(0)) dut_b0 (.CLK(clk), .RST(rst), .bus(ifb0.slave));
   add_mop_seq #(.width(16), .depth(5), .speed(1)) dut_b1 (.CLK(clk), .RST(rst), .bus(ifb1.slave));
   add_mop_seq #(.width(16), .depth(5), .speed(2)) dut_b2 (.CLK(clk), .RST(rst), .bus(ifb2.slave));

   logic        vb, sb, srb;
   logic [15:0] ab;
   assign ifb0.AValid = vb;  assign ifb0.A = ab; assign ifb0.ASub = sb; assign ifb0.SReady = srb;
   assign ifb1.AValid = vb;  assign ifb1.A = ab; assign ifb1.ASub = sb; assign ifb1.SReady = srb;
   assign ifb2.AValid = vb;  assign ifb2.A = ab; assign ifb2.ASub = sb; assign ifb2.SReady = srb;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int nres_b = 0;
   logic [7:0]  qa[$];
   logic [15:0] qb0[$], qb1[$], qb2[$];
   int          hs_cyc[$];

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm, input logic [63:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got sum %0h expected no sum", nm, act);
   endtask

   always @(negedge clk) begin
      if (!rst && ifa.SValid === 1'b1 && ifa.SReady === 1'b1) begin
         if (qa.size() == 0) unexpected("unexpected_sum_a", 64'(ifa.S));
         else chk("sum_a", 64'(ifa.S), 64'(qa.pop_front()));
         hs_cyc.push_back(cyc);
      end
   end

   always @(negedge clk) begin
      if (!rst && ifb0.SValid === 1'b1 && srb === 1'b1) begin
         if (qb0.size() == 0) unexpected("unexpected_sum_b0", 64'(ifb0.S));
         else chk("sum_b0_ripple", 64'(ifb0.S), 64'(qb0.pop_front()));
         nres_b++;
      end
   end

   always @(negedge clk) begin
      if (!rst && ifb1.SValid === 1'b1 && srb === 1'b1) begin
         if (qb1.size() == 0) unexpected("unexpected_sum_b1", 64'(ifb1.S));
         else chk("sum_b1_brentkung", 64'(ifb1.S), 64'(qb1.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (!rst && ifb2.SValid === 1'b1 && srb === 1'b1) begin
         if (qb2.size() == 0) unexpected("unexpected_sum_b2", 64'(ifb2.S));
         else chk("sum_b2_sklansky", 64'(ifb2.S), 64'(qb2.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic put(input logic [7:0] a, input logic s);
      logic acc;
      int   n;
      ifa.AValid = 1'b1;
      ifa.A      = a;
      ifa.ASub   = s;
      acc        = 1'b0;
      n          = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = ifa.AReady;
         @(posedge clk);
         #1;
         n++;
      end
      ifa.AValid = 1'b0;
      if (!acc) chk("put_timeout", 64'(acc), 64'd1);
   endtask

   task automatic run_set(input logic [31:0] ops, input logic [3:0] subs, input bit gap,
                          input bit push, input logic [7:0] exp);
      if (push) qa.push_back(exp);
      for (int k = 0; k < 4; k++) begin
         put(ops[8*k +: 8], subs[k]);
         if (gap) tick();
      end
   endtask

   // Returns at the negedge where SValid is seen high.
   task automatic wait_sv();
      int n;
      n = 0;
      @(negedge clk);
      while (ifa.SValid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (ifa.SValid !== 1'b1) chk("wait_svalid_timeout", 64'(ifa.SValid), 64'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] acc;
      int          cnt;
      int          n;
      int          hs_n;

      rst = 1'b1;
      ifa.AValid = 1'b0; ifa.A = '0; ifa.ASub = 1'b0; ifa.SReady = 1'b0;
      vb = 1'b0; ab = '0; sb = 1'b0; srb = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      chk("reset_aready", 64'(ifa.AReady), 64'd0);
      chk("reset_svalid", 64'(ifa.SValid), 64'd0);
      chk("reset_s",      64'(ifa.S),      64'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("aready_after_reset", 64'(ifa.AReady), 64'd1);
      tick();

      // Basic set with latency and handshake-recovery checks.
      ifa.SReady = 1'b1;
      run_set({8'd40, 8'd30, 8'd20, 8'd10}, 4'b0000, 1'b0, 1'b1, 8'd100);
      @(negedge clk);
      chk("resolve_svalid", 64'(ifa.SValid), 64'd0);
      chk("resolve_aready", 64'(ifa.AReady), 64'd0);
      @(negedge clk);
      chk("latency_svalid", 64'(ifa.SValid), 64'd1);
      @(negedge clk);
      chk("aready_after_hs", 64'(ifa.AReady), 64'd1);
      chk("svalid_after_hs", 64'(ifa.SValid), 64'd0);
      tick();

      // Back-to-back sets: overflow, mixed signs, all-subtract wrap.
      hs_n = hs_cyc.size();
      run_set({8'd255, 8'd255, 8'd255, 8'd255}, 4'b0000, 1'b0, 1'b1, 8'd252);
      run_set({8'd20, 8'd0, 8'd3, 8'd10},       4'b1010, 1'b0, 1'b1, 8'd243);
      run_set({8'd1, 8'd1, 8'd1, 8'd1},         4'b1111, 1'b0, 1'b1, 8'd252);
      repeat (4) tick();
      if (hs_cyc.size() >= hs_n + 3) begin
         chk("throughput_1", 64'(hs_cyc[hs_n+1] - hs_cyc[hs_n]), 64'd6);
         chk("throughput_2", 64'(hs_cyc[hs_n+2] - hs_cyc[hs_n+1]), 64'd6);
      end else begin
         chk("throughput_count", 64'(hs_cyc.size() - hs_n), 64'd3);
      end

      // AValid toggling gives the same sum.
      run_set({8'd40, 8'd30, 8'd20, 8'd10}, 4'b0000, 1'b1, 1'b1, 8'd100);
      repeat (4) tick();

      // Output backpressure with operand noise in DONE.
      ifa.SReady = 1'b0;
      run_set({8'd8, 8'd7, 8'd6, 8'd5}, 4'b0000, 1'b0, 1'b1, 8'd26);
      wait_sv();
      tick();
      for (int k = 0; k < 5; k++) begin
         ifa.AValid = 1'b1;
         ifa.A      = 8'($urandom);
         ifa.ASub   = 1'($urandom);
         @(negedge clk);
         chk("stall_svalid", 64'(ifa.SValid), 64'd1);
         chk("stall_s",      64'(ifa.S),      64'd26);
         chk("stall_aready", 64'(ifa.AReady), 64'd0);
         tick();
      end
      ifa.AValid = 1'b0;
      ifa.SReady = 1'b1;
      repeat (3) tick();

      // Reset after two accepts.
      put(8'd50, 1'b0);
      put(8'd60, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_aready", 64'(ifa.AReady), 64'd0);
      chk("midrst_svalid", 64'(ifa.SValid), 64'd0);
      chk("midrst_s",      64'(ifa.S),      64'd0);
      tick();
      rst = 1'b0;
      run_set({8'd4, 8'd3, 8'd2, 8'd1}, 4'b0000, 1'b0, 1'b1, 8'd10);
      repeat (4) tick();

      // Reset while the result is held in DONE; that result must never appear.
      ifa.SReady = 1'b0;
      run_set({8'd9, 8'd9, 8'd9, 8'd9}, 4'b0000, 1'b0, 1'b0, 8'd0);
      wait_sv();
      #1;
      rst = 1'b1;
      #1;
      chk("donerst_svalid", 64'(ifa.SValid), 64'd0);
      chk("donerst_s",      64'(ifa.S),      64'd0);
      chk("donerst_aready", 64'(ifa.AReady), 64'd0);
      tick();
      rst = 1'b0;
      ifa.SReady = 1'b1;
      run_set({8'd4, 8'd3, 8'd2, 8'd1}, 4'b0000, 1'b0, 1'b1, 8'd10);
      repeat (4) tick();
      chk("queue_a_empty", 64'(qa.size()), 64'd0);

      // Random sets on the three adder architectures.
      acc = '0;
      cnt = 0;
      n   = 0;
      while (nres_b < 1000 && n < 40000) begin
         vb  = ($urandom % 4) != 0;
         ab  = 16'($urandom);
         sb  = 1'($urandom);
         srb = ($urandom % 4) != 0;
         @(negedge clk);
         if (vb && ifb0.AReady) begin
            acc = acc + (sb ? (~ab + 16'd1) : ab);
            cnt++;
            if (cnt == 5) begin
               qb0.push_back(acc);
               qb1.push_back(acc);
               qb2.push_back(acc);
               acc = '0;
               cnt = 0;
            end
         end
         @(posedge clk);
         #1;
         n++;
      end
      vb  = 1'b0;
      srb = 1'b1;
      repeat (6) tick();
      chk("random_sets_done", 64'(nres_b >= 1000), 64'd1);
      chk("queue_b0_empty", 64'(qb0.size()), 64'd0);
      chk("queue_b1_empty", 64'(qb1.size()), 64'd0);
      chk("queue_b2_empty", 64'(qb2.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
